// File: rtl/wiscsc15_mc_ctrl.sv
// Multi-cycle control FSM for the WISC-SC15 datapath: fetch/decode/execute/memory/write-back
// sequencing with memory wait-state timeout. Define WISC_PERF_CNT_EN to build the cycle/retire counters.
module wiscsc15_mc_ctrl #(
  parameter int INSTR_W  = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  output logic               imem_req,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  input  logic               cond_true,
  output logic               ir_load,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               rf_we,
  output logic [1:0]         rf_wsrc,
  output logic [2:0]         aluop,
  output logic               flags_we,
  output logic [2:0]         state,
  output logic               halted,
  output logic               err_timeout,
  output logic [31:0]        cyc_cnt,
  output logic [31:0]        instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;
  // Last wait count at which an ack is still accepted.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state_q;
  logic [3:0] op_q;
  logic [7:0] wait_q;
  logic       err_q;
  logic       unused_s;

  assign unused_s = ^instr[INSTR_W-5:0];

  function automatic state_t exec_next(input logic [3:0] op);
    case (op)
      OP_LW, OP_SW:  return S_MEM;
      OP_B, OP_RET:  return S_FETCH;
      OP_HLT:        return S_HALT;
      default:       return S_WB;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= 4'd0;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            op_q    <= instr[INSTR_W-1 -: 4];
            wait_q  <= 8'd0;
            state_q <= S_DECODE;
          end else if (wait_q == WAIT_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else begin
            wait_q  <= wait_q + 8'd1;
          end
        end
        S_DECODE: begin
          wait_q  <= 8'd0;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          wait_q  <= 8'd0;
          state_q <= exec_next(op_q);
        end
        S_MEM: begin
          if (dmem_ack) begin
            wait_q  <= 8'd0;
            state_q <= (op_q == OP_SW) ? S_FETCH : S_WB;
          end else if (wait_q == WAIT_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else begin
            wait_q  <= wait_q + 8'd1;
          end
        end
        S_WB: begin
          wait_q  <= 8'd0;
          state_q <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Control decode; FETCH outputs are gated by rst_n so nothing fires while held in reset.
  always_comb begin
    imem_req = 1'b0;
    ir_load  = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 2'd0;
    rf_we    = 1'b0;
    rf_wsrc  = 2'd0;
    aluop    = 3'd0;
    flags_we = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = rst_n;
        ir_load  = rst_n & imem_ack;
        pc_we    = rst_n & imem_ack;
      end
      S_EXEC: begin
        case (op_q)
          OP_B:    begin pc_we = cond_true; pc_src = 2'd1; end
          OP_CALL: begin pc_we = 1'b1;      pc_src = 2'd2; end
          OP_RET:  begin pc_we = 1'b1;      pc_src = 2'd3; end
          default: aluop = op_q[3] ? 3'd0 : op_q[2:0];
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_SW);
      end
      S_WB: begin
        rf_we    = 1'b1;
        flags_we = (op_q <= 4'd4);
        if (!op_q[3]) begin
          rf_wsrc = 2'd0;
        end else if (op_q == OP_LW) begin
          rf_wsrc = 2'd1;
        end else if (op_q == OP_CALL) begin
          rf_wsrc = 2'd2;
        end else begin
          rf_wsrc = 2'd3;
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign state       = state_q;
  assign err_timeout = err_q;

`ifdef WISC_PERF_CNT_EN
  logic        retire_s;
  logic [31:0] cyc_q;
  logic [31:0] ret_q;

  assign retire_s = (state_q == S_WB) ||
                    (state_q == S_EXEC && (op_q == OP_B || op_q == OP_RET || op_q == OP_HLT)) ||
                    (state_q == S_MEM && dmem_ack && op_q == OP_SW);

  // Free-running cycle counter and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= 32'd0;
      ret_q <= 32'd0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (retire_s) begin
        ret_q <= ret_q + 32'd1;
      end
    end
  end

  assign cyc_cnt   = cyc_q;
  assign instr_cnt = ret_q;
`else
  assign cyc_cnt   = 32'd0;
  assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_wiscsc15_mc_ctrl.sv
// Scoreboard bench for wiscsc15_mc_ctrl: per-cycle expected control vectors are queued as stimulus is driven.
module tb_wiscsc15_mc_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, cond_true = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_load, pc_we, rf_we, flags_we, halted, err_timeout;
  logic [1:0]  pc_src, rf_wsrc;
  logic [2:0]  aluop, state;
  logic [31:0] cyc_cnt, instr_cnt;

  int errors = 0;
  int checks = 0;
  int k = 0;
  int ret = 0;
  logic [18:0] exp_q[$];

  wiscsc15_mc_ctrl #(.INSTR_W(16), .WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .cond_true(cond_true),
    .ir_load(ir_load), .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .rf_wsrc(rf_wsrc),
    .aluop(aluop), .flags_we(flags_we), .state(state), .halted(halted),
    .err_timeout(err_timeout), .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  wire [18:0] got = {state, imem_req, ir_load, pc_we, pc_src, rf_we, rf_wsrc, aluop,
                     flags_we, dmem_req, dmem_we, halted, err_timeout};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, expv, k);
    end
  endtask

  function automatic logic [18:0] ev(input logic [2:0] st, input logic ireq, input logic irl,
      input logic pcwe, input logic [1:0] pcs, input logic rfwe, input logic [1:0] wsrc,
      input logic [2:0] aop, input logic fwe, input logic dreq, input logic dwe,
      input logic hlt, input logic err);
    return {st, ireq, irl, pcwe, pcs, rfwe, wsrc, aop, fwe, dreq, dwe, hlt, err};
  endfunction

  task automatic check_perf(input string tag);
`ifdef WISC_PERF_CNT_EN
    check({tag, "/cyc_cnt"}, cyc_cnt, 32'(k));
    check({tag, "/instr_cnt"}, instr_cnt, 32'(ret));
`else
    check({tag, "/cyc_cnt"}, cyc_cnt, 32'd0);
    check({tag, "/instr_cnt"}, instr_cnt, 32'd0);
`endif
  endtask

  // Drive one cycle's inputs, then compare against the queued expectation; no clock advance.
  task automatic cyc_nb(input logic ia, input logic [15:0] ins, input logic da, input logic ct,
                        input logic [18:0] expv, input string tag);
    imem_ack = ia; instr = ins; dmem_ack = da; cond_true = ct;
    exp_q.push_back(expv);
    #1;
    check(tag, 32'(got), 32'(exp_q.pop_front()));
    check_perf(tag);
  endtask

  task automatic cyc(input logic ia, input logic [15:0] ins, input logic da, input logic ct,
                     input logic [18:0] expv, input string tag);
    cyc_nb(ia, ins, da, ct, expv, tag);
    @(posedge clk);
    #2;
    k++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1; cond_true = 1'b1;
    #1;
    k = 0; ret = 0;
    check("rst_outs", 32'(got), 32'd0);
    check("rst_cnt", cyc_cnt | instr_cnt, 32'd0);
    @(posedge clk);
    #2;
    check("rst_hold", 32'(got), 32'd0);
    rst_n = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic exec_instr(input logic [3:0] op, input logic ct, input int iw, input int dw,
                            input logic abort_wb);
    logic [15:0] ins;
    logic        pcwe;
    logic [1:0]  pcs, wsrc;
    logic [2:0]  aop;
    ins = {op, 12'hA5C};
    for (int i = 0; i < iw; i++)
      cyc(1'b0, ins, 1'b0, ct, ev(3'd0,1'b1,1'b0,1'b0,2'd0,1'b0,2'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0), "fetch_wait");
    cyc(1'b1, ins, 1'b0, ct, ev(3'd0,1'b1,1'b1,1'b1,2'd0,1'b0,2'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0), "fetch");
    cyc(1'b1, ins, 1'b1, ct, ev(3'd1,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0), "decode");
    pcwe = 1'b0; pcs = 2'd0;
    aop = op[3] ? 3'd0 : op[2:0];
    if (op == 4'hC) begin pcwe = ct;   pcs = 2'd1; end
    if (op == 4'hD) begin pcwe = 1'b1; pcs = 2'd2; end
    if (op == 4'hE) begin pcwe = 1'b1; pcs = 2'd3; end
    cyc(1'b1, ins, 1'b1, ct, ev(3'd2,1'b0,1'b0,pcwe,pcs,1'b0,2'd0,aop,1'b0,1'b0,1'b0,1'b0,1'b0), "exec");
    if (op == 4'hC || op == 4'hE) begin
      ret++;
      return;
    end
    if (op == 4'hF) begin
      ret++;
      cyc(1'b1, ins, 1'b1, ct, ev(3'd5,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,3'd0,1'b0,1'b0,1'b0,1'b1,1'b0), "halt");
      cyc(1'b1, ins, 1'b1, ct, ev(3'd5,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,3'd0,1'b0,1'b0,1'b0,1'b1,1'b0), "halt_stay");
      return;
    end
    if (op == 4'h8 || op == 4'h9) begin
      for (int i = 0; i < dw; i++)
        cyc(1'b1, ins, 1'b0, ct, ev(3'd3,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,3'd0,1'b0,1'b1,op == 4'h9,1'b0,1'b0), "mem_wait");
      cyc(1'b1, ins, 1'b1, ct, ev(3'd3,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,3'd0,1'b0,1'b1,op == 4'h9,1'b0,1'b0), "mem");
      if (op == 4'h9) begin
        ret++;
        return;
      end
    end
    wsrc = !op[3] ? 2'd0 : (op == 4'h8) ? 2'd1 : (op == 4'hD) ? 2'd2 : 2'd3;
    if (abort_wb) begin
      cyc_nb(1'b1, ins, 1'b1, ct, ev(3'd4,1'b0,1'b0,1'b0,2'd0,1'b1,wsrc,3'd0,op <= 4'd4,1'b0,1'b0,1'b0,1'b0), "wb");
      do_reset();
    end else begin
      cyc(1'b1, ins, 1'b1, ct, ev(3'd4,1'b0,1'b0,1'b0,2'd0,1'b1,wsrc,3'd0,op <= 4'd4,1'b0,1'b0,1'b0,1'b0), "wb");
      ret++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    do_reset();
    // ADD, SW, HLT: HALT entry lands on cycle 11 with three retirements.
    exec_instr(4'h0, 1'b0, 0, 0, 1'b0);
    exec_instr(4'h9, 1'b0, 0, 0, 1'b0);
    exec_instr(4'hF, 1'b0, 0, 0, 1'b0);

    do_reset();
    exec_instr(4'h8, 1'b0, 0, 3, 1'b0);
    exec_instr(4'hC, 1'b0, 0, 0, 1'b0);
    exec_instr(4'hC, 1'b1, 0, 0, 1'b0);
    exec_instr(4'hD, 1'b0, 1, 0, 1'b0);
    exec_instr(4'hE, 1'b0, 0, 0, 1'b0);
    exec_instr(4'hA, 1'b0, 0, 0, 1'b0);
    exec_instr(4'hB, 1'b0, 0, 0, 1'b0);
    exec_instr(4'h2, 1'b0, 2, 0, 1'b0);
    exec_instr(4'h4, 1'b0, 0, 0, 1'b0);
    exec_instr(4'h5, 1'b0, 0, 0, 1'b0);
    exec_instr(4'h7, 1'b0, 0, 0, 1'b0);
    exec_instr(4'h1, 1'b0, 0, 0, 1'b0);
    exec_instr(4'h9, 1'b0, 2, 1, 1'b0);
    exec_instr(4'h3, 1'b0, 0, 0, 1'b1);

    // Instruction fetch never acknowledged: ERR after the 15th waiting cycle.
    for (int i = 0; i < 15; i++)
      cyc(1'b0, 16'h0000, 1'b0, 1'b0, ev(3'd0,1'b1,1'b0,1'b0,2'd0,1'b0,2'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0), "to_wait");
    cyc(1'b1, 16'h0000, 1'b1, 1'b0, ev(3'd6,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b1), "to_err");
    cyc(1'b1, 16'h0000, 1'b1, 1'b0, ev(3'd6,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b1), "to_sticky");

    // Ack arriving on the 15th fetch cycle is accepted.
    do_reset();
    exec_instr(4'h0, 1'b0, 14, 0, 1'b0);
    exec_instr(4'h8, 1'b0, 0, 14, 1'b0);
    exec_instr(4'hF, 1'b0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wiscsc15_mc_ctrl.md
# wiscsc15_mc_ctrl

Multi-cycle control unit for the WISC-SC15 16-bit datapath. It generalises the single-cycle combinational decoder into a parametrised FSM that sequences fetch, decode, execute, memory and write-back. It runs variable-latency instruction and data memory handshakes with a wait-state timeout, and it drives PC, register-file, ALU and data-memory controls from the latched opcode.

## Interface
Parameters:
- INSTR_W, 16: instruction width; opcode is instr[INSTR_W-1:INSTR_W-4].
- WAIT_MAX, 15: maximum cycles a memory request may stay unacknowledged before timeout, 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  INSTR_W  instruction word from imem, valid when imem_ack=1.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch complete.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req.
- dmem_ack  in  1  data access complete.
- cond_true  in  1  branch condition evaluated by the flag unit.
- ir_load  out  1  latch instr into the IR.
- pc_we  out  1  PC write enable.
- pc_src  out  2  0 = PC+1, 1 = branch target, 2 = call target, 3 = register (RET).
- rf_we  out  1  register-file write enable.
- rf_wsrc  out  2  0 = ALU, 1 = dmem data, 2 = PC+1 (CALL link), 3 = immediate (LHB/LLB).
- aluop  out  3  ALU operation.
- flags_we  out  1  update flags.
- state  out  3  current FSM state.
- halted  out  1  HLT executed.
- err_timeout  out  1  sticky memory timeout.
- cyc_cnt  out  32  cycles since reset (see Configuration).
- instr_cnt  out  32  retired instructions (see Configuration).

## Operation
- Opcodes:
  - 0000 ADD, 0001 PADDSB, 0010 SUB, 0011 AND, 0100 NOR, 0101 SLL, 0110 SRL, 0111 SRA.
  - 1000 LW, 1001 SW, 1010 LHB, 1011 LLB.
  - 1100 B, 1101 CALL, 1110 RET, 1111 HLT.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_load=1, pc_we=1, pc_src=0 in the same cycle; the opcode is latched internally; go to DECODE.
- DECODE: one cycle, no outputs asserted; go to EXEC.
- EXEC:
  - ALU ops 0000-0111: aluop=opcode[2:0]; go to WB.
  - LW/SW: aluop=0 (address add); go to MEM.
  - LHB/LLB: go to WB.
  - B: pc_we=cond_true, pc_src=1; go to FETCH.
  - CALL: pc_we=1, pc_src=2; go to WB.
  - RET: pc_we=1, pc_src=3; go to FETCH.
  - HLT: go to HALT.
- MEM:
  - dmem_req=1, dmem_we=(opcode==SW).
  - On dmem_ack: LW goes to WB; SW goes to FETCH.
- WB:
  - rf_we=1.
  - rf_wsrc: ALU ops → 0, LW → 1, CALL → 2, LHB/LLB → 3.
  - flags_we=1 for ADD, PADDSB, SUB, AND, NOR only.
  - Go to FETCH.
- HALT: halted=1, all requests 0; exit only by reset.
- Wait counter:
  - Clears on entering FETCH or MEM and increments each cycle the request is unacknowledged.
  - When the count reaches WAIT_MAX without an ack: go to ERR and set err_timeout.
  - ERR: all outputs 0 except err_timeout=1; exit only by reset.
  - Ack in the same cycle the count hits WAIT_MAX: the ack wins and there is no error.
- All outputs are 0 in any state/opcode combination not listed above.

## Timing
- Reset (rst_n=0): state=FETCH, counters and sticky flags cleared, every output 0 (imem_req is gated by rst_n).
- The first imem_req is asserted in the first cycle after rst_n rises.
- Minimum latencies, zero wait states, measured from fetch cycle to next fetch cycle:
  - ALU, LHB, LLB, CALL: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - B, RET: 3 cycles.
  - HLT: reaches HALT 3 cycles after its fetch cycle.
- Each memory wait cycle adds one cycle.
- Requests are held high continuously until ack, and drop in the cycle after ack.
- An instruction retires on:
  - the WB→FETCH transition;
  - EXEC→FETCH (B, RET);
  - MEM→FETCH (SW);
  - EXEC→HALT (HLT).
- Reset asserted mid-operation aborts immediately; no partial writes follow.

## Configuration
- WISC_PERF_CNT_EN defined:
  - cyc_cnt increments every cycle out of reset, including HALT/ERR; it wraps at 2^32.
  - instr_cnt increments once per retired instruction.
- WISC_PERF_CNT_EN undefined: both ports are present and tied to 0, and no counter flops exist.

## Test plan
- ADD, zero waits, imem_ack high → states 0,1,2,4,0; aluop=000 in EXEC; rf_we=1, rf_wsrc=0, flags_we=1 in WB; 4 cycles.
- LW with dmem_ack delayed 3 cycles → dmem_req high 4 cycles with dmem_we=0; WB rf_wsrc=1; 8 cycles total.
- B with cond_true=0, then B with cond_true=1 → pc_we=0, then pc_we=1 with pc_src=1 in EXEC; each returns to FETCH after 3 cycles.
- imem_ack held low, WAIT_MAX=15 → state=6 and err_timeout=1 after 15 cycles; ack in cycle 15 of a separate run → no error.
- HLT, then reset pulse mid-WB of a following program → halted=1 stays in state 5; rst_n low clears all outputs within the same cycle.
- WISC_PERF_CNT_EN defined, ADD, SW, HLT → instr_cnt=3, cyc_cnt=11 at HALT entry; undefined → both 0.
